// File: rtl/ifmap_pkg.sv
// Shared definitions for the ifmap byte-to-word packer.
// Lane order is LSB-first by default; define IFMAP_PACKER_MSB_FIRST_EN for MSB-first.
package ifmap_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_e;

    // Lane that the k-th received byte of a word occupies.
    function automatic int unsigned lane_idx(input int unsigned k, input int unsigned nbytes);
`ifdef IFMAP_PACKER_MSB_FIRST_EN
        return nbytes - 1 - k;
`else
        return (k < nbytes) ? k : 0;
`endif
    endfunction

endpackage

// File: rtl/ifmap_packer.sv
// Serial-to-parallel ifmap packer: 8-bit byte stream in, BUS+1-bit words out.
// Build option: IFMAP_PACKER_MSB_FIRST_EN places the first byte in the top lane.
module ifmap_packer
    import ifmap_pkg::*;
#(
    parameter int BUS = 31
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [BYTE_W-1:0]                     in_byte,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [BUS:0]                          out_word,
    output logic [$clog2((BUS+1)/BYTE_W+1)-1:0]   out_nbytes
);

    localparam int NBYTES = (BUS + 1) / BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    pack_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BUS:0]      asm_q, asm_d;
    logic [BUS:0]      out_word_q, out_word_d;
    logic [CNT_W-1:0]  out_nbytes_q, out_nbytes_d;
    logic              out_valid_q, out_valid_d;

    logic              slot_free;
    logic              byte_acc;
    logic              completing;
    int unsigned       lane_sel;
    logic [BUS:0]      merged;

    assign slot_free  = !out_valid_q || out_ready;
    assign byte_acc   = in_valid && (state_q == FILL);
    assign completing = byte_acc && ((cnt_q == CNT_W'(NBYTES - 1)) || in_last);
    assign lane_sel   = lane_idx(32'(cnt_q), NBYTES);

    // Assembly register with the incoming byte dropped into its lane.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign merged[gi*BYTE_W +: BYTE_W] =
                (lane_sel == gi) ? in_byte : asm_q[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (completing && !slot_free) state_d = HOLD;
            HOLD: if (slot_free) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        in_ready = (state_q == FILL);
    end

    // In HOLD, cnt_q carries the byte count of the parked word.
    always_comb begin
        cnt_d        = cnt_q;
        asm_d        = asm_q;
        out_word_d   = out_word_q;
        out_nbytes_d = out_nbytes_q;
        out_valid_d  = out_valid_q && !out_ready;
        if (state_q == FILL) begin
            if (byte_acc) begin
                if (completing && slot_free) begin
                    out_word_d   = merged;
                    out_nbytes_d = cnt_q + CNT_W'(1);
                    out_valid_d  = 1'b1;
                    cnt_d        = '0;
                    asm_d        = '0;
                end else begin
                    asm_d = merged;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else if (slot_free) begin
            out_word_d   = asm_q;
            out_nbytes_d = cnt_q;
            out_valid_d  = 1'b1;
            cnt_d        = '0;
            asm_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            out_word_q   <= '0;
            out_nbytes_q <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            out_word_q   <= out_word_d;
            out_nbytes_q <= out_nbytes_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign out_word   = out_word_q;
    assign out_nbytes = out_nbytes_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_ifmap_packer.sv
// Bench for ifmap_packer: directed table, hand-written stall/reset/partial sequences,
// and randomized traffic against a queue-based packing model.
module tb_ifmap_packer;

    localparam int BUS    = 31;
    localparam int NBYTES = (BUS + 1) / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_byte = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [BUS:0]     out_word;
    logic [CNT_W-1:0] out_nbytes;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    ifmap_packer #(.BUS(BUS)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_nbytes (out_nbytes)
    );

    typedef struct {
        logic [7:0]   b;
        logic         last;
        logic         exp_valid;
        logic [BUS:0] exp_word;
        int           exp_n;
    } vec_t;

    typedef struct {
        logic [BUS:0] word;
        int           n;
    } wrd_t;

    // Reference model: bytes of the word being built and words owed downstream.
    logic [7:0]   cur_q[$];
    wrd_t         exp_q[$];
    logic         stall_prev = 1'b0;
    logic [BUS:0] prev_word;
    int           prev_n;

    task automatic check(input string nm, input logic [BUS:0] act, input logic [BUS:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [BUS:0] pack_bytes(input logic [7:0] bs[$]);
        logic [BUS:0] w = '0;
        for (int k = 0; k < bs.size(); k++) begin
`ifdef IFMAP_PACKER_MSB_FIRST_EN
            w[(NBYTES - 1 - k)*8 +: 8] = bs[k];
`else
            w[k*8 +: 8] = bs[k];
`endif
        end
        return w;
    endfunction

    // Runs at the falling edge, ahead of the rising edge that acts on these values.
    task automatic sb_sample();
        wrd_t e;
        if (rst) begin
            cur_q.delete();
            exp_q.delete();
            stall_prev = 1'b0;
            return;
        end
        if (stall_prev) begin
            check("stall_word", out_word, prev_word);
            check("stall_n", BUS'(out_nbytes), BUS'(prev_n));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sb_word", out_word, e.word);
                check("sb_n", BUS'(out_nbytes), BUS'(e.n));
            end
        end
        if (in_valid && in_ready) begin
            cur_q.push_back(in_byte);
            if (cur_q.size() == NBYTES || in_last) begin
                e.word = pack_bytes(cur_q);
                e.n    = cur_q.size();
                exp_q.push_back(e);
                cur_q.delete();
            end
        end
        stall_prev = out_valid && !out_ready;
        prev_word  = out_word;
        prev_n     = int'(out_nbytes);
    endtask

    task automatic step();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        logic acc = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = in_ready;
            step();
        end
        if (!acc) check("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    vec_t tbl[10];
    logic [BUS:0] w_full, w_part, w_seq, w_hi, w_lo, w_rst, w_one, w_c;

    initial begin
`ifdef IFMAP_PACKER_MSB_FIRST_EN
        w_full = 32'h11223344; w_part = 32'hAABB0000; w_seq = 32'h01020304;
        w_lo = 32'h01020304; w_hi = 32'h05060708; w_rst = 32'h55667788;
        w_c = 32'h11223344; w_one = 32'h5A000000;
`else
        w_full = 32'h44332211; w_part = 32'h0000BBAA; w_seq = 32'h04030201;
        w_lo = 32'h04030201; w_hi = 32'h08070605; w_rst = 32'h88776655;
        w_c = 32'h44332211; w_one = 32'h0000005A;
`endif
        tbl[0] = '{8'h11, 1'b0, 1'b0, '0, 0};
        tbl[1] = '{8'h22, 1'b0, 1'b0, '0, 0};
        tbl[2] = '{8'h33, 1'b0, 1'b0, '0, 0};
        tbl[3] = '{8'h44, 1'b0, 1'b1, w_full, 4};
        tbl[4] = '{8'hAA, 1'b0, 1'b0, '0, 0};
        tbl[5] = '{8'hBB, 1'b1, 1'b1, w_part, 2};
        tbl[6] = '{8'h01, 1'b0, 1'b0, '0, 0};
        tbl[7] = '{8'h02, 1'b0, 1'b0, '0, 0};
        tbl[8] = '{8'h03, 1'b0, 1'b0, '0, 0};
        tbl[9] = '{8'h04, 1'b0, 1'b1, w_seq, 4};

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", BUS'(out_valid), '0);
        check("rst_word", out_word, '0);
        check("rst_n", BUS'(out_nbytes), '0);
        check("rst_in_ready", BUS'(in_ready), 1);

        // Back-to-back bytes with out_ready held high.
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            in_valid = 1'b1;
            in_byte  = tbl[i].b;
            in_last  = tbl[i].last;
            step();
            check("tbl_valid", BUS'(out_valid), BUS'(tbl[i].exp_valid));
            check("tbl_in_ready", BUS'(in_ready), 1);
            if (tbl[i].exp_valid) begin
                check("tbl_word", out_word, tbl[i].exp_word);
                check("tbl_n", BUS'(out_nbytes), BUS'(tbl[i].exp_n));
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        check("drain_valid", BUS'(out_valid), '0);

        // Output stalled: second word parks in the assembly register.
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) send_byte(8'(k), 1'b0);
        check("stall1_valid", BUS'(out_valid), 1);
        check("stall1_word", out_word, w_lo);
        for (int k = 5; k <= 8; k++) send_byte(8'(k), 1'b0);
        check("hold_in_ready", BUS'(in_ready), '0);
        check("hold_word", out_word, w_lo);
        out_ready = 1'b1;
        step();
        check("release_valid", BUS'(out_valid), 1);
        check("release_word", out_word, w_hi);
        check("release_n", BUS'(out_nbytes), 4);
        check("release_in_ready", BUS'(in_ready), 1);
        step();
        check("release_drain", BUS'(out_valid), '0);

        // Reset mid-word discards the partial word.
        for (int k = 0; k < 3; k++) send_byte(8'hE0 + 8'(k), 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", BUS'(out_valid), '0);
        check("midrst_word", out_word, '0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        check("postrst_word", out_word, w_rst);
        check("postrst_n", BUS'(out_nbytes), 4);
        step();

        // Single-byte word while the previous word is unconsumed.
        out_ready = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h5A, 1'b1);
        check("one_hold", BUS'(in_ready), '0);
        check("one_prev", out_word, w_c);
        out_ready = 1'b1;
        step();
        check("one_word", out_word, w_one);
        check("one_n", BUS'(out_nbytes), 1);
        check("one_valid", BUS'(out_valid), 1);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst       = (i == 300);
            in_valid  = ($urandom_range(3) != 0);
            in_byte   = 8'($urandom);
            in_last   = ($urandom_range(4) == 0);
            out_ready = ($urandom_range(2) != 0);
            step();
        end
        rst = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("rand_drained", BUS'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
